// File: rtl/fpu_pkg.sv
// Shared single-precision constants and field layout for the FP datapath blocks.
package fpu_pkg;

    localparam int unsigned EXP_MAX  = 255;
    localparam int unsigned EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fmul_core.sv
// Combinational single-precision multiply: truncating, denormals flushed to zero,
// saturating to signed infinity on exponent overflow.
module fmul_core
    import fpu_pkg::*;
(
    input  fp32_t       a_i,
    input  fp32_t       b_i,
    output logic        sign_o,
    output logic [7:0]  exp_o,
    output logic [22:0] frac_o,
    output logic        error_o,
    output logic        overflow_o
);

    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic        norm;
    int          exp_sum;
    logic        unused_prod;

    assign unused_prod = ^prod[22:0];

    always_comb begin
        a_zero  = (a_i.exp == 8'd0);
        b_zero  = (b_i.exp == 8'd0);
        a_inf   = (a_i.exp == 8'(EXP_MAX)) && (a_i.frac == '0);
        b_inf   = (b_i.exp == 8'(EXP_MAX)) && (b_i.frac == '0);
        a_nan   = (a_i.exp == 8'(EXP_MAX)) && (a_i.frac != '0);
        b_nan   = (b_i.exp == 8'(EXP_MAX)) && (b_i.frac != '0);
        prod    = 48'({1'b1, a_i.frac}) * 48'({1'b1, b_i.frac});
        norm    = prod[47];
        exp_sum = int'(a_i.exp) + int'(b_i.exp) - int'(EXP_BIAS) + int'(norm);

        sign_o     = a_i.sign ^ b_i.sign;
        exp_o      = '0;
        frac_o     = '0;
        error_o    = 1'b0;
        overflow_o = 1'b0;

        if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            {sign_o, exp_o, frac_o} = QNAN;
            error_o                 = 1'b1;
        end else if (a_nan || b_nan) begin
            {sign_o, exp_o, frac_o} = QNAN;
        end else if (a_inf || b_inf) begin
            exp_o  = POS_INF[30:23];
            frac_o = POS_INF[22:0];
        end else if (a_zero || b_zero || exp_sum <= 0) begin
            // Signed zero: defaults already hold it.
            exp_o = '0;
        end else if (exp_sum >= int'(EXP_MAX)) begin
            exp_o      = POS_INF[30:23];
            frac_o     = POS_INF[22:0];
            overflow_o = 1'b1;
        end else begin
            exp_o  = exp_sum[7:0];
            frac_o = norm ? prod[46:24] : prod[45:23];
        end
    end

endmodule

// File: rtl/fmul_sched.sv
// Shares one fmul_core among NREQ requesters through a two-stage pipeline.
// Define FMUL_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module fmul_sched
    import fpu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_error,
    output logic                 rsp_overflow
);

    logic [3:0]   valid_pad;
    logic [127:0] a_pad, b_pad;

    assign valid_pad = 4'(req_valid);
    assign a_pad     = 128'(req_a);
    assign b_pad     = 128'(req_b);

    logic       pick_vld;
    logic [1:0] pick_id;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic       hold;
    logic       xfer;
    logic       s1_adv, s2_adv;

    logic       lock_q, lock_d;
    logic [1:0] lock_id_q, lock_id_d;

    logic        s1_valid_q, s1_valid_d;
    fp32_t       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [1:0]  s1_id_q, s1_id_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic [1:0]  s2_id_q, s2_id_d;
    logic        s2_err_q, s2_err_d;
    logic        s2_ovf_q, s2_ovf_d;

    logic        core_sign, core_err, core_ovf;
    logic [7:0]  core_exp;
    logic [22:0] core_frac;

`ifdef FMUL_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_id  = ptr_q;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!pick_vld && valid_pad[idx[1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = idx[1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (int'(grant_id) == int'(NREQ) - 1) ? 2'd0 : grant_id + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (valid_pad[k]) begin
                pick_vld = 1'b1;
                pick_id  = 2'(k);
            end
        end
    end
`endif

    // A stalled requester keeps its grant until it transfers.
    always_comb begin
        hold      = lock_q && valid_pad[lock_id_q];
        grant_vld = hold || pick_vld;
        grant_id  = hold ? lock_id_q : pick_id;
        s2_adv    = !s2_valid_q || rsp_ready;
        s1_adv    = s2_adv || !s1_valid_q;
        xfer      = rst_n && grant_vld && s1_adv;
        lock_d    = grant_vld && !s1_adv;
        lock_id_d = grant_id;
        req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ready[i] = xfer && (grant_id == 2'(i));
        end
    end

    fmul_core u_core (
        .a_i        (s1_a_q),
        .b_i        (s1_b_q),
        .sign_o     (core_sign),
        .exp_o      (core_exp),
        .frac_o     (core_frac),
        .error_o    (core_err),
        .overflow_o (core_ovf)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        s2_err_d   = s2_err_q;
        s2_ovf_d   = s2_ovf_q;
        if (s1_adv) begin
            s1_valid_d = xfer;
            if (xfer) begin
                s1_a_d  = a_pad[{grant_id, 5'b0} +: 32];
                s1_b_d  = b_pad[{grant_id, 5'b0} +: 32];
                s1_id_d = grant_id;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = {core_sign, core_exp, core_frac};
                s2_id_d   = s1_id_q;
                s2_err_d  = core_err;
                s2_ovf_d  = core_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            s2_err_q   <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            s2_err_q   <= s2_err_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign rsp_valid    = s2_valid_q;
    assign rsp_id       = s2_id_q;
    assign rsp_data     = s2_data_q;
    assign rsp_error    = s2_err_q;
    assign rsp_overflow = s2_ovf_q;

endmodule

// File: tb/tb_fmul_sched.sv
// Scoreboard bench for fmul_sched: directed special cases, arbitration order,
// backpressure, mid-flight reset and randomised traffic.
module tb_fmul_sched;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a, req_b;
    logic                 rsp_valid, rsp_ready;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_error, rsp_overflow;

    always #5 clk = ~clk;

    fmul_sched #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .rsp_overflow (rsp_overflow)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic        err;
        logic        ovf;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb_q[$];
    int          xfer_ids[$];
    int          xfer_cnt;
    int          want[NREQ];
    logic        rand_bp;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference product: {err, ovf, data}; operands are never NaN here.
    function automatic logic [33:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        logic            s, a_inf, b_inf, a_z, b_z;
        int              e;
        longint unsigned p;
        s     = a[31] ^ b[31];
        a_inf = (a[30:23] == 8'hFF);
        b_inf = (b[30:23] == 8'hFF);
        a_z   = (a[30:23] == 8'h00);
        b_z   = (b[30:23] == 8'h00);
        if ((a_inf && b_z) || (a_z && b_inf)) return {2'b10, 32'h7FC00000};
        if (a_inf || b_inf) return {2'b00, s, 31'h7F800000};
        if (a_z || b_z) return {2'b00, s, 31'h0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin
            p = p >> 1;
            e = e + 1;
        end
        if (e <= 0) return {2'b00, s, 31'h0};
        if (e >= 255) return {2'b01, s, 31'h7F800000};
        return {2'b00, s, 8'(e), p[45:23]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:0] = 31'h7F800000;
            1:       v[30:23] = 8'h00;
            default: v[30:23] = 8'($urandom_range(60, 195));
        endcase
        return v;
    endfunction

    // Monitor: push on transfer, pop on response, check stability under stall.
    initial begin
        rsp_t held;
        rsp_t exp;
        logic hold_chk;
        hold_chk = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    check_eq("hold_valid", 64'(rsp_valid), 64'd1);
                    check_eq("hold_fields", 64'({rsp_id, rsp_error, rsp_overflow, rsp_data}),
                             64'(held));
                end
                hold_chk = rsp_valid && !rsp_ready;
                held     = {rsp_id, rsp_error, rsp_overflow, rsp_data};
                if (req_ready != '0) check_eq("ready_onehot", 64'($countones(req_ready)), 64'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        sb_q.push_back({2'(i), fmul_model(req_a[32*i +: 32], req_b[32*i +: 32])});
                        xfer_ids.push_back(i);
                        xfer_cnt++;
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("stale_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        exp = sb_q.pop_front();
                        check_eq("rsp", 64'({rsp_id, rsp_error, rsp_overflow, rsp_data}), 64'(exp));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic refresh(input logic [NREQ-1:0] fired);
        for (int i = 0; i < NREQ; i++) begin
            if (fired[i] && want[i] > 0) want[i]--;
            if (want[i] == 0) begin
                req_valid[i] = 1'b0;
            end else if (fired[i] || !req_valid[i]) begin
                req_a[32*i +: 32] = rand_op();
                req_b[32*i +: 32] = rand_op();
                req_valid[i]      = 1'b1;
            end
        end
        if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_cycles(input int n);
        logic [NREQ-1:0] fired;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            fired = req_valid & req_ready;
            @(posedge clk);
            #1;
            refresh(fired);
        end
    endtask

    task automatic drain();
        int n;
        n         = 0;
        rand_bp   = 1'b0;
        rsp_ready = 1'b1;
        while ((want[0] + want[1] != 0 || sb_q.size() != 0 || rsp_valid) && n < 200) begin
            run_cycles(1);
            n++;
        end
        check_eq("drain_sb", 64'(sb_q.size()), 64'd0);
        check_eq("drain_reqs", 64'(want[0] + want[1]), 64'd0);
    endtask

    task automatic send_one(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_data, input logic exp_err,
                            input logic exp_ovf, input string tag);
        req_valid          = '0;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]      = 1'b1;
        rsp_ready          = 1'b1;
        #1;
        check_eq({tag, "_ready"}, 64'(req_ready[id]), 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        check_eq({tag, "_lat1"}, 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check_eq({tag, "_result"}, 64'({rsp_id, rsp_error, rsp_overflow, rsp_data}),
                 64'({2'(id), exp_err, exp_ovf, exp_data}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rand_bp   = 1'b0;
        xfer_cnt  = 0;
        want      = '{default: 0};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp", 64'({rsp_valid, rsp_id, rsp_data, rsp_error, rsp_overflow}), 64'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        send_one(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, "mul_1p5x2");
        send_one(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, "inf_x_zero");
        send_one(0, 32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, "zero_x_ninf");
        send_one(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1, "overflow");
        send_one(0, 32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0, "inf_x_ninf");
        send_one(1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, "neg_product");
        send_one(0, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0, "underflow");
        send_one(1, 32'h80400000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, "denorm_flush");

        // Stall the output: two transfers fill S1 and S2, then ready drops.
        xfer_cnt  = 0;
        rsp_ready = 1'b0;
        want[0]   = 4;
        want[1]   = 4;
        refresh('0);
        run_cycles(6);
        check_eq("bp_xfers", 64'(xfer_cnt), 64'd2);
        check_eq("bp_ready", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        drain();

        // Reset with both stages full; nothing in flight may emerge later.
        rsp_ready = 1'b0;
        want[0]   = 3;
        want[1]   = 3;
        refresh('0);
        run_cycles(3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_mid_ready", 64'(req_ready), 64'd0);
        rst_n     = 1'b1;
        req_valid = '0;
        want      = '{default: 0};
        rsp_ready = 1'b1;

        // Continuous contention straight after reset.
        xfer_ids.delete();
        want[0] = 6;
        want[1] = 6;
        refresh('0);
        run_cycles(14);
        check_eq("stream_count", 64'(xfer_ids.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < xfer_ids.size(); k++) begin
`ifdef FMUL_SCHED_RR_EN
            check_eq($sformatf("stream_id%0d", k), 64'(xfer_ids[k]), 64'(k % 2));
`else
            check_eq($sformatf("stream_id%0d", k), 64'(xfer_ids[k]), 64'd0);
`endif
        end
        drain();

        // Random operands with random output backpressure.
        rand_bp = 1'b1;
        want[0] = 20;
        want[1] = 20;
        refresh('0);
        run_cycles(60);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fmul_sched.md
FMUL_SCHED -- requirements
Module: fmul_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning the number of requesters sharing the multiplier (legal range 2..4).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, NREQ bits, per-requester operation valid.
REQ-005 SHALL have port req_ready, output, NREQ bits, per-requester accept.
REQ-006 SHALL have port req_a, input, 32*NREQ bits, operand A per requester (requester i occupies [32i+31:32i]), IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-007 SHALL have port req_b, input, 32*NREQ bits, operand B per requester, with the same layout as req_a.
REQ-008 SHALL have port rsp_valid, output, 1 bit, result valid.
REQ-009 SHALL have port rsp_ready, input, 1 bit, downstream accept.
REQ-010 SHALL have port rsp_id, output, 2 bits, index of the requester that issued the result.
REQ-011 SHALL have port rsp_data, output, 32 bits, product {sign, exp, frac[22:0]}.
REQ-012 SHALL have port rsp_error, output, 1 bit, invalid operation (inf*0).
REQ-013 SHALL have port rsp_overflow, output, 1 bit, result saturated to infinity.

Function
REQ-014 SHALL transfer request i on any cycle where req_valid[i] and req_ready[i] are both high; at most one req_ready bit is high per cycle.
REQ-015 SHALL be a two-stage pipeline: S1 holds latched operands and id; S2 holds the registered core result and id; rsp_* are driven from S2.
REQ-016 SHALL present a result accepted at edge N with rsp_valid high after edge N+1, i.e. latency 2 cycles; throughput is 1 op/cycle while rsp_ready is high.
REQ-017 SHALL advance S2 when S2 is empty or rsp_ready is high; S1 advances when S2 advances or S1 is empty.
REQ-018 SHALL drive req_ready[i] = grant[i] AND S1-can-accept, where grant is a one-hot choice among asserted req_valid bits.
REQ-019 SHALL hold rsp_valid, rsp_id, rsp_data, rsp_error and rsp_overflow stable while rsp_valid is high and rsp_ready is low; no result is dropped or duplicated.
REQ-020 SHALL compute sign = A.sign XOR B.sign, with the fraction truncated (no rounding).
REQ-021 SHALL treat an operand with exp==0 as zero (denormals flush to zero).
REQ-022 SHALL return 0x7F800000 with sign applied for inf*inf, with rsp_error=0.
REQ-023 SHALL return 0x7FC00000 with rsp_error=1 for inf*0 or 0*inf.
REQ-024 SHALL return signed zero when either operand is zero or the biased exponent underflows (≤0).
REQ-025 SHALL return signed infinity with rsp_overflow=1 when the biased exponent is ≥255.
REQ-026 SHALL leave NaN-operand results unspecified while keeping rsp_error=0; these results SHALL NOT be relied upon.
REQ-027 SHALL update the priority pointer only on a transfer, setting it to (winner+1) mod NREQ; a request with no transfer keeps the pointer unchanged.
REQ-028 SHALL not drop a request whose valid is held while req_ready is low, and SHALL not change the grant while the requester waits (grant is stable under backpressure).

Reset
REQ-029 SHALL, while rst_n is low at a clock edge, clear S1/S2 valid, set the priority pointer to 0, and drive req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_error=0 and rsp_overflow=0.
REQ-030 SHALL discard in-flight operations on reset mid-operation, with no result emitted for them afterward.

Configuration
REQ-031 SHALL, with macro FMUL_SCHED_RR_EN defined, arbitrate round-robin per REQ-027.
REQ-032 SHALL, without FMUL_SCHED_RR_EN, use fixed priority (lowest index wins) with the pointer logic omitted.

Structure
REQ-033 SHALL take the constants EXP_MAX=255, EXP_BIAS=127, QNAN=32'h7FC00000 and POS_INF=32'h7F800000, plus a typedef for the 32-bit float fields, from the shared package fpu_pkg.
REQ-034 SHALL instantiate exactly one combinational sub-module, fmul_core (operands in; sign/exp/frac/error/overflow out), placed between S1 and S2.

Verification
REQ-035 SHALL cover: req 0 sends 0x3FC00000 × 0x40000000 -> rsp_data=0x40400000, rsp_id=0, rsp_valid two cycles after transfer.
REQ-036 SHALL cover: 0x7F800000 × 0x00000000 -> rsp_data=0x7FC00000, rsp_error=1; 0x7F000000 × 0x7F000000 -> 0x7F800000, rsp_overflow=1.
REQ-037 SHALL cover: both requesters continuously valid, rsp_ready=1, FMUL_SCHED_RR_EN defined -> rsp_id sequence 0,1,0,1…; without the macro -> all results on id 0.
REQ-038 SHALL cover: rsp_ready held 0 for 6 cycles with both valid -> exactly 2 transfers then req_ready=0, rsp_* stable, and all results delivered in order after release.
REQ-039 SHALL cover: rst_n asserted for 1 cycle with S1 and S2 full -> next cycle rsp_valid=0, then the pointer favours id 0 and no stale result appears.
